sram_port_arbiter: RTL and testbench

//  Shares one external async SRAM chip between two core-side buses (port 0 = CPU, port 1 = video/DMA).

---
 rtl/retro1_sram_pkg.sv | 26 ++
 rtl/sram_rr_arbiter.sv | 32 +++
 rtl/sram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retro1_sram_pkg.sv
// Shared types and constants for the two-port async SRAM arbiter.
package retro1_sram_pkg;

  // Native geometry of the board SRAM; the latched request struct is sized from these.
  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 16;

  // Arbitration policy selector values.
  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } sram_state_e;

  // One accepted core-side request, held for the whole SRAM access.
  typedef struct packed {
    logic                   write;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [1:0]             be;
  } sram_req_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way request picker: round-robin against the last granted port, or
// fixed priority with port 1 winning. Grants nothing unless accept_i is high.
module sram_rr_arbiter
  import retro1_sram_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       mode_i,
  input  logic       last_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // Pick a single port; on contention RR favours the port not granted last.
  always_comb begin
    grant_o = 2'b00;
    if (accept_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11: begin
          if ((mode_i == ARB_FIXED) || (last_i == 1'b0)) begin
            grant_o = 2'b10;
          end else begin
            grant_o = 2'b01;
          end
        end
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one external async SRAM between a CPU port (0) and a video/DMA
// port (1). Requests are accepted with valid/ready, the SRAM strobes are
// sequenced with a fixed number of wait states and a one-cycle completion
// pulse is returned to the owning port. ADDR_W/DATA_W must match the
// package geometry because the latched request struct is sized from it.
module sram_port_arbiter
  import retro1_sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Pause,
  input  logic [1:0]             ReqValid,
  output logic [1:0]             ReqReady,
  input  logic [1:0]             ReqWrite,
  input  logic [1:0][ADDR_W-1:0] ReqAddr,
  input  logic [1:0][DATA_W-1:0] ReqWData,
  input  logic [1:0][1:0]        ReqBE,
  output logic [1:0]             RspValid,
  output logic [DATA_W-1:0]      RspRData,
  output logic [ADDR_W-1:0]      SramAddr,
  output logic [DATA_W-1:0]      SramDqOut,
  output logic                   SramDqOe,
  input  logic [DATA_W-1:0]      SramDqIn,
  output logic                   SramCe_n,
  output logic                   SramOe_n,
  output logic                   SramWe_n,
  output logic                   SramLb_n,
  output logic                   SramUb_n
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
  localparam logic       ARB_SEL   = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;

  sram_state_e       state_q, state_d;
  logic [2:0]        waitCnt_q, waitCnt_d;
  sram_req_t         req_q, req_d;
  logic              port_q, port_d;
  logic              lastPort_q, lastPort_d;
  logic [1:0]        rspValid_q, rspValid_d;
  logic [DATA_W-1:0] rspRData_q, rspRData_d;
  logic              ceN_q, ceN_d;
  logic              oeN_q, oeN_d;
  logic              weN_q, weN_d;
  logic              lbN_q, lbN_d;
  logic              ubN_q, ubN_d;
  logic              dqOe_q, dqOe_d;

  logic              grantEn;
  logic [1:0]        grant;
  logic              pick;
  logic              nextAccess;

  // New work is only taken while idle, running and out of reset.
  assign grantEn = Reset && !Pause && (state_q == IDLE);

  sram_rr_arbiter uArb (
    .req_i   (ReqValid),
    .mode_i  (ARB_SEL),
    .last_i  (lastPort_q),
    .accept_i(grantEn),
    .grant_o (grant)
  );

  assign ReqReady = grant;
  assign pick     = grant[1];

  // Next-state, request latch, response and registered pin values.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    req_d      = req_q;
    port_d     = port_q;
    lastPort_d = lastPort_q;
    rspValid_d = 2'b00;
    rspRData_d = rspRData_q;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          port_d      = pick;
          lastPort_d  = pick;
          req_d.write = ReqWrite[pick];
          req_d.addr  = ReqAddr[pick];
          req_d.wdata = ReqWData[pick];
          req_d.be    = ReqBE[pick];
          waitCnt_d   = WAIT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (waitCnt_q == 3'd0) begin
          rspValid_d[port_q] = 1'b1;
          if (req_q.write) begin
            state_d = RECOVER;
          end else begin
            rspRData_d = SramDqIn;
            state_d    = IDLE;
          end
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    nextAccess = (state_d == ACCESS);
    ceN_d  = !nextAccess;
    oeN_d  = !(nextAccess && !req_d.write);
    weN_d  = !(nextAccess && req_d.write);
    dqOe_d = nextAccess && req_d.write;
    lbN_d  = nextAccess ? (req_d.write ? !req_d.be[0] : 1'b0) : 1'b1;
    ubN_d  = nextAccess ? (req_d.write ? !req_d.be[1] : 1'b0) : 1'b1;
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 3'd0;
      req_q      <= '0;
      port_q     <= 1'b0;
      lastPort_q <= 1'b1;
      rspValid_q <= 2'b00;
      rspRData_q <= '0;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
      lbN_q      <= 1'b1;
      ubN_q      <= 1'b1;
      dqOe_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      req_q      <= req_d;
      port_q     <= port_d;
      lastPort_q <= lastPort_d;
      rspValid_q <= rspValid_d;
      rspRData_q <= rspRData_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
      lbN_q      <= lbN_d;
      ubN_q      <= ubN_d;
      dqOe_q     <= dqOe_d;
    end
  end

  assign RspValid  = rspValid_q;
  assign RspRData  = rspRData_q;
  assign SramAddr  = req_q.addr;
  assign SramDqOut = req_q.wdata;
  assign SramDqOe  = dqOe_q;
  assign SramCe_n  = ceN_q;
  assign SramOe_n  = oeN_q;
  assign SramWe_n  = weN_q;
  assign SramLb_n  = lbN_q;
  assign SramUb_n  = ubN_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one round-robin and one fixed-priority
// instance, each with its own SRAM pin model, checked every cycle against a
// transaction-timing reference model.
module tb_sram_port_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int W  = 1;

  typedef struct {
    bit          valid;
    bit          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]  be;
  } req_t;

  typedef struct {
    bit          active;
    int          t;
    bit          port;
    bit          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]  be;
    logic [DW-1:0] rdata;
  } txn_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Pause = 1'b0;

  logic [1:0]          reqValid [2];
  logic [1:0]          reqReady [2];
  logic [1:0]          reqWrite [2];
  logic [1:0][AW-1:0]  reqAddr  [2];
  logic [1:0][DW-1:0]  reqWData [2];
  logic [1:0][1:0]     reqBE    [2];
  logic [1:0]          rspValid [2];
  logic [DW-1:0]       rspRData [2];
  logic [AW-1:0]       sramAddr [2];
  logic [DW-1:0]       sramDqOut[2];
  logic                sramDqOe [2];
  logic [DW-1:0]       sramDqIn [2];
  logic                ceN [2];
  logic                oeN [2];
  logic                weN [2];
  logic                lbN [2];
  logic                ubN [2];

  // Stimulus and reference-model state.
  req_t          pend [2][2];
  txn_t          cur [2];
  bit            lastPort [2];
  bit            addrZero [2];
  logic [DW-1:0] expRData [2];
  logic [DW-1:0] pinMem [int];
  logic [DW-1:0] refMem [int];
  logic [AW-1:0] addrPool [6];
  bit            rstDrv;
  bit            pauseDrv;
  bit            logOn;
  int            grantSeq [2][8];
  int            grantCnt [2];
  int            issued [2][2];
  int            cyc;
  int            checkCount;
  int            errorCount;

  // Free-running 100 MHz clock.
  always #5 Clk = ~Clk;

  for (genvar k = 0; k < 2; k++) begin : gDut
    sram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .ARB_MODE(k)
    ) dut (
      .Clk(Clk), .Reset(Reset), .Pause(Pause),
      .ReqValid(reqValid[k]), .ReqReady(reqReady[k]), .ReqWrite(reqWrite[k]),
      .ReqAddr(reqAddr[k]), .ReqWData(reqWData[k]), .ReqBE(reqBE[k]),
      .RspValid(rspValid[k]), .RspRData(rspRData[k]),
      .SramAddr(sramAddr[k]), .SramDqOut(sramDqOut[k]), .SramDqOe(sramDqOe[k]),
      .SramDqIn(sramDqIn[k]),
      .SramCe_n(ceN[k]), .SramOe_n(oeN[k]), .SramWe_n(weN[k]),
      .SramLb_n(lbN[k]), .SramUb_n(ubN[k])
    );
  end

  function automatic int memKey(int k, logic [AW-1:0] a);
    return k * (1 << AW) + int'(a);
  endfunction

  function automatic logic [DW-1:0] memInit(logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] pinRead(int k, logic [AW-1:0] a);
    if (pinMem.exists(memKey(k, a))) return pinMem[memKey(k, a)];
    return memInit(a);
  endfunction

  function automatic logic [DW-1:0] refRead(int k, logic [AW-1:0] a);
    if (refMem.exists(memKey(k, a))) return refMem[memKey(k, a)];
    return memInit(a);
  endfunction

  function automatic req_t mkReq(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] be);
    req_t r;
    r.valid = 1'b1;
    r.write = wr;
    r.addr  = a;
    r.wdata = d;
    r.be    = be;
    return r;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Registered outputs of instance k for the current cycle, from the txn timeline.
  task automatic checkPins(int k);
    bit acc;
    bit rsp;
    logic [5:0] expStrobe;
    acc = cur[k].active && (cyc >= cur[k].t + 1) && (cyc <= cur[k].t + 1 + W);
    rsp = cur[k].active && (cyc == cur[k].t + W + 2);
    if (rsp && !cur[k].write) expRData[k] = cur[k].rdata;
    expStrobe = 6'b111110;
    if (acc && cur[k].write) expStrobe = {1'b0, 1'b1, 1'b0, ~cur[k].be[0], ~cur[k].be[1], 1'b1};
    if (acc && !cur[k].write) expStrobe = 6'b001000;
    checkOutput($sformatf("strobes[%0d]@%0d", k, cyc),
                32'({ceN[k], oeN[k], weN[k], lbN[k], ubN[k], sramDqOe[k]}), 32'(expStrobe));
    checkOutput($sformatf("rspValid[%0d]@%0d", k, cyc), 32'(rspValid[k]),
                rsp ? 32'(2'b01 << cur[k].port) : 32'd0);
    checkOutput($sformatf("rspRData[%0d]@%0d", k, cyc), 32'(rspRData[k]), 32'(expRData[k]));
    if (acc) checkOutput($sformatf("sramAddr[%0d]@%0d", k, cyc), 32'(sramAddr[k]), 32'(cur[k].addr));
    if (acc && cur[k].write)
      checkOutput($sformatf("dqOut[%0d]@%0d", k, cyc), 32'(sramDqOut[k]), 32'(cur[k].wdata));
    if (addrZero[k]) begin
      checkOutput($sformatf("rstAddr[%0d]@%0d", k, cyc), 32'(sramAddr[k]), 32'd0);
      checkOutput($sformatf("rstDqOut[%0d]@%0d", k, cyc), 32'(sramDqOut[k]), 32'd0);
    end
  endtask

  // The chip itself: byte-lane writes while We_n is low, data out while Oe_n is low.
  task automatic sramPins(int k);
    logic [DW-1:0] old;
    if (!ceN[k] && !weN[k]) begin
      old = pinRead(k, sramAddr[k]);
      pinMem[memKey(k, sramAddr[k])] = {ubN[k] ? old[15:8] : sramDqOut[k][15:8],
                                        lbN[k] ? old[7:0]  : sramDqOut[k][7:0]};
    end
    if (!ceN[k] && !oeN[k]) sramDqIn[k] = pinRead(k, sramAddr[k]);
    else sramDqIn[k] = 16'hDEAD;
  endtask

  task automatic applyStimulus();
    Reset = rstDrv;
    Pause = pauseDrv;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        reqValid[k][p] = pend[k][p].valid;
        reqWrite[k][p] = pend[k][p].write;
        reqAddr[k][p]  = pend[k][p].addr;
        reqWData[k][p] = pend[k][p].wdata;
        reqBE[k][p]    = pend[k][p].be;
      end
    end
  endtask

  // Reference decision for instance k this cycle: who gets accepted, if anyone.
  task automatic modelAccept(int k);
    bit free;
    int p;
    logic [1:0] expReady;
    logic [DW-1:0] old;
    free = !cur[k].active || (cyc >= cur[k].t + W + 2 + (cur[k].write ? 1 : 0));
    p = -1;
    if (rstDrv && !pauseDrv && free) begin
      if (pend[k][0].valid && pend[k][1].valid) p = (k == 1) ? 1 : (lastPort[k] ? 0 : 1);
      else if (pend[k][1].valid) p = 1;
      else if (pend[k][0].valid) p = 0;
    end
    expReady = (p < 0) ? 2'b00 : 2'(2'b01 << p);
    checkOutput($sformatf("reqReady[%0d]@%0d", k, cyc), 32'(reqReady[k]), 32'(expReady));
    if (p >= 0) begin
      cur[k].active = 1'b1;
      cur[k].t      = cyc;
      cur[k].port   = p[0];
      cur[k].write  = pend[k][p].write;
      cur[k].addr   = pend[k][p].addr;
      cur[k].wdata  = pend[k][p].wdata;
      cur[k].be     = pend[k][p].be;
      old = refRead(k, pend[k][p].addr);
      cur[k].rdata  = old;
      if (pend[k][p].write)
        refMem[memKey(k, pend[k][p].addr)] = {pend[k][p].be[1] ? pend[k][p].wdata[15:8] : old[15:8],
                                              pend[k][p].be[0] ? pend[k][p].wdata[7:0]  : old[7:0]};
      lastPort[k] = p[0];
      addrZero[k] = 1'b0;
      pend[k][p].valid = 1'b0;
      if (logOn && grantCnt[k] < 8) begin
        grantSeq[k][grantCnt[k]] = p;
        grantCnt[k]++;
      end
    end
    if (!rstDrv) begin
      cur[k].active = 1'b0;
      lastPort[k]   = 1'b1;
      expRData[k]   = '0;
      addrZero[k]   = 1'b1;
    end
  endtask

  task automatic stepCycle();
    @(negedge Clk);
    cyc++;
    for (int k = 0; k < 2; k++) checkPins(k);
    for (int k = 0; k < 2; k++) sramPins(k);
    applyStimulus();
    #1;
    for (int k = 0; k < 2; k++) modelAccept(k);
  endtask

  task automatic clearPend();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) pend[k][p].valid = 1'b0;
  endtask

  // Directed scenarios first, then a long randomized run.
  initial begin
    addrPool[0] = 19'h00123; addrPool[1] = 19'h7FFFF; addrPool[2] = 19'h00456;
    addrPool[3] = 19'h00000; addrPool[4] = 19'h3ABCD; addrPool[5] = 19'h00124;
    cyc = 0; checkCount = 0; errorCount = 0; logOn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cur[k].active = 1'b0; lastPort[k] = 1'b1; addrZero[k] = 1'b1; expRData[k] = '0;
      grantCnt[k] = 0; sramDqIn[k] = '0;
      for (int p = 0; p < 2; p++) begin
        pend[k][p] = mkReq(1'b0, addrPool[p], 16'h0, 2'b11);
        issued[k][p] = 0;
      end
    end
    rstDrv = 1'b0; pauseDrv = 1'b0;
    applyStimulus();

    // Reset held with both ports requesting.
    repeat (3) stepCycle();
    clearPend();
    rstDrv = 1'b1;
    repeat (2) stepCycle();

    // Port 0 read of a known word.
    for (int k = 0; k < 2; k++) begin
      pinMem[memKey(k, 19'h00123)] = 16'hBEEF;
      refMem[memKey(k, 19'h00123)] = 16'hBEEF;
      pend[k][0] = mkReq(1'b0, 19'h00123, 16'h0, 2'b11);
    end
    repeat (6) stepCycle();
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("beefRead[%0d]", k), 32'(rspRData[k]), 32'h0000BEEF);

    // Port 1 upper-byte write at the top address.
    for (int k = 0; k < 2; k++) begin
      pinMem[memKey(k, 19'h7FFFF)] = 16'h1212;
      refMem[memKey(k, 19'h7FFFF)] = 16'h1212;
      pend[k][1] = mkReq(1'b1, 19'h7FFFF, 16'hA55A, 2'b10);
    end
    repeat (7) stepCycle();
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("ubWrite[%0d]", k), 32'(pinRead(k, 19'h7FFFF)), 32'h0000A512);

    // Both ports stream four reads each.
    logOn = 1'b1;
    for (int c = 0; c < 80; c++) begin
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          if (!pend[k][p].valid && issued[k][p] < 4) begin
            pend[k][p] = mkReq(1'b0, addrPool[$urandom_range(0, 5)], 16'h0, 2'b11);
            issued[k][p]++;
          end
      stepCycle();
    end
    logOn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("grantCount[%0d]", k), 32'(grantCnt[k]), 32'd8);
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("grantOrder[%0d][%0d]", k, i), 32'(grantSeq[k][i]),
                    (k == 0) ? 32'(i % 2) : ((i < 4) ? 32'd1 : 32'd0));
    end

    // Pause raised during an access, port 1 waiting behind it.
    for (int k = 0; k < 2; k++) pend[k][0] = mkReq(1'b0, 19'h00456, 16'h0, 2'b11);
    stepCycle();
    pauseDrv = 1'b1;
    for (int k = 0; k < 2; k++) pend[k][1] = mkReq(1'b0, 19'h00124, 16'h0, 2'b11);
    repeat (8) stepCycle();
    pauseDrv = 1'b0;
    repeat (6) stepCycle();

    // Reset in the second cycle of a write access.
    for (int k = 0; k < 2; k++) pend[k][0] = mkReq(1'b1, 19'h00456, 16'h1111, 2'b11);
    stepCycle();
    stepCycle();
    rstDrv = 1'b0;
    stepCycle();
    rstDrv = 1'b1;
    repeat (6) stepCycle();

    // Randomized traffic with occasional pause and reset.
    for (int c = 0; c < 1500; c++) begin
      rstDrv   = ($urandom_range(0, 249) != 0);
      pauseDrv = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          pend[k][p] = mkReq(1'($urandom_range(0, 1)), addrPool[$urandom_range(0, 5)],
                             16'($urandom), 2'($urandom_range(0, 3)));
          pend[k][p].valid = ($urandom_range(0, 3) != 0);
        end
      stepCycle();
    end
    rstDrv = 1'b1; pauseDrv = 1'b0;
    clearPend();
    repeat (8) stepCycle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
